// File: rtl/serv_trace_fifo_if.sv
// Trace drain port of serv_trace_fifo: first-word-fall-through valid/ready
// handshake together with the fields of the head record.
interface serv_trace_fifo_if;
  logic        tr_valid;
  logic        tr_ready;
  logic [31:0] tr_pc;
  logic [31:0] tr_insn;
  logic [4:0]  tr_rd_addr;
  logic [31:0] tr_rd_wdata;
  logic        tr_trap;
  logic [15:0] tr_seq;

  modport master (
    output tr_valid, tr_pc, tr_insn, tr_rd_addr, tr_rd_wdata, tr_trap, tr_seq,
    input  tr_ready
  );

  modport slave (
    input  tr_valid, tr_pc, tr_insn, tr_rd_addr, tr_rd_wdata, tr_trap, tr_seq,
    output tr_ready
  );
endinterface

// File: rtl/serv_trace_fifo.sv
// Instruction-retirement trace buffer for the bit-serial core. Collects the
// serial rd write data, instruction word, PC and trap flag of each retired
// instruction and queues one record per retirement in a DEPTH-entry FIFO that
// is drained through a first-word-fall-through valid/ready port.
module serv_trace_fifo #(
  parameter int          W         = 1,
  parameter int          DEPTH     = 8,
  parameter bit          OVERWRITE = 1'b0,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_ibus_ack,
  input  logic [31:0]               i_ibus_rdt,
  input  logic [31:0]               i_ibus_adr,
  input  logic                      i_rf_wen,
  input  logic [W-1:0]              i_rf_wdata,
  input  logic [4:0]                i_rd_addr,
  input  logic                      i_cnt_done,
  input  logic                      i_ctrl_pc_en,
  input  logic                      i_trap,
  input  logic                      i_clr_overflow,
  serv_trace_fifo_if.master         tr,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
    logic [15:0] seq;
  } rec_t;

  rec_t          mem [DEPTH];

  logic [31:0]   insn_r;
  logic [31:0]   rd_sr_r;
  logic [31:0]   pc_r;
  logic          rd_seen_r;
  logic          trap_seen_r;
  logic          pending_r;
  logic [15:0]   seq_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;

  rec_t          rec_s;
  logic          retire_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          do_write_s;
  logic          adv_rd_s;
  logic          ovf_set_s;
  logic [CW-1:0] count_nxt_s;

  // Retirement is delayed one cycle so the last rd chunk is already shifted in
  assign retire_s = i_cnt_done & i_ctrl_pc_en & ~i_rst;

  // Assemble the record for the instruction committing this cycle
  always_comb begin
    rec_s.pc      = pc_r;
    rec_s.insn    = insn_r;
    if (rd_seen_r && (i_rd_addr != 5'd0)) begin
      rec_s.rd_addr  = i_rd_addr;
      rec_s.rd_wdata = rd_sr_r;
    end else begin
      rec_s.rd_addr  = 5'd0;
      rec_s.rd_wdata = 32'h0000_0000;
    end
    rec_s.trap    = trap_seen_r | i_trap;
    rec_s.seq     = seq_r;
  end

  // FIFO control: push/pop decisions, full-policy handling and next occupancy
  always_comb begin
    push_s      = pending_r & i_en & ~i_rst;
    pop_s       = (count_r != {CW{1'b0}}) & tr.tr_ready;
    full_s      = (count_r == CW'(DEPTH));
    do_write_s  = push_s & (~full_s | pop_s | OVERWRITE);
    adv_rd_s    = pop_s | (push_s & full_s & OVERWRITE);
    ovf_set_s   = push_s & full_s & ~pop_s;
    if (do_write_s && !adv_rd_s) begin
      count_nxt_s = count_r + CW'(1);
    end else if (!do_write_s && adv_rd_s) begin
      count_nxt_s = count_r - CW'(1);
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Per-instruction capture: insn word, serial rd data, trap, PC and sequence
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      insn_r      <= 32'h0000_0000;
      rd_sr_r     <= 32'h0000_0000;
      rd_seen_r   <= 1'b0;
      trap_seen_r <= 1'b0;
      pending_r   <= 1'b0;
      pc_r        <= RESET_PC;
      seq_r       <= 16'h0000;
    end else begin
      pending_r <= retire_s;
      if (i_ibus_ack) begin
        insn_r <= i_ibus_rdt;
      end
      if (i_rf_wen) begin
        rd_sr_r <= {i_rf_wdata, rd_sr_r[31:W]};
      end
      if (pending_r) begin
        pc_r        <= i_ibus_adr;
        seq_r       <= seq_r + 16'd1;
        rd_seen_r   <= 1'b0;
        trap_seen_r <= 1'b0;
      end else begin
        rd_seen_r   <= rd_seen_r | i_rf_wen;
        trap_seen_r <= trap_seen_r | i_trap;
      end
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (do_write_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (adv_rd_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (i_clr_overflow) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Record storage, written at the tail on each accepted push
  always_ff @(posedge i_clk) begin
    if (do_write_s) begin
      mem[wr_ptr_r] <= rec_s;
    end
  end

  assign tr.tr_valid    = (count_r != {CW{1'b0}});
  assign tr.tr_pc       = mem[rd_ptr_r].pc;
  assign tr.tr_insn     = mem[rd_ptr_r].insn;
  assign tr.tr_rd_addr  = mem[rd_ptr_r].rd_addr;
  assign tr.tr_rd_wdata = mem[rd_ptr_r].rd_wdata;
  assign tr.tr_trap     = mem[rd_ptr_r].trap;
  assign tr.tr_seq      = mem[rd_ptr_r].seq;
  assign o_count        = count_r;
  assign o_overflow     = overflow_r;

endmodule

// File: tb/tb_serv_trace_fifo.sv
// Bench for serv_trace_fifo: two instances (W=1 drop-on-full, W=4 evict-oldest)
// share one stimulus stream; a monitor compares each drained record against a
// per-instance queue of expected records.
module tb_serv_trace_fifo;

  localparam logic [31:0] RPC = 32'h0000_1000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        trap;
    logic [15:0] seq;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst, en, ack, wen, wd1, cnt_done, pc_en, trap, clr, ready;
  logic [31:0] rdt, adr;
  logic [3:0]  wd4;
  logic [4:0]  rda;
  logic [3:0]  cnt0, cnt1;
  logic        ovf0, ovf1;

  int          vectors    = 0;
  int          miscompares = 0;
  rec_t        q0[$];
  rec_t        q1[$];
  logic [31:0] m_pc;
  logic [15:0] m_seq;

  always #5 clk = ~clk;

  serv_trace_fifo_if tr0();
  serv_trace_fifo_if tr1();
  assign tr0.tr_ready = ready;
  assign tr1.tr_ready = ready;

  serv_trace_fifo #(.W(1), .DEPTH(8), .OVERWRITE(1'b0), .RESET_PC(RPC)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_ibus_ack(ack), .i_ibus_rdt(rdt),
    .i_ibus_adr(adr), .i_rf_wen(wen), .i_rf_wdata(wd1), .i_rd_addr(rda),
    .i_cnt_done(cnt_done), .i_ctrl_pc_en(pc_en), .i_trap(trap),
    .i_clr_overflow(clr), .tr(tr0), .o_count(cnt0), .o_overflow(ovf0)
  );

  serv_trace_fifo #(.W(4), .DEPTH(8), .OVERWRITE(1'b1), .RESET_PC(RPC)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_ibus_ack(ack), .i_ibus_rdt(rdt),
    .i_ibus_adr(adr), .i_rf_wen(wen), .i_rf_wdata(wd4), .i_rd_addr(rda),
    .i_cnt_done(cnt_done), .i_ctrl_pc_en(pc_en), .i_trap(trap),
    .i_clr_overflow(clr), .tr(tr1), .o_count(cnt1), .o_overflow(ovf1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected-record queues follow each instance's full policy
  task automatic exp_push(input rec_t r, input bit same_pop);
    if (same_pop || q0.size() < 8) q0.push_back(r);
    if (same_pop || q1.size() < 8) begin
      q1.push_back(r);
    end else begin
      void'(q1.pop_front());
      q1.push_back(r);
    end
  endtask

  task automatic mon(input int id, input rec_t act);
    rec_t e;
    vectors++;
    if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
      miscompares++;
      $display("FAIL dut%0d unexpected record seq=%0d", id, act.seq);
    end else begin
      if (id == 0) e = q0.pop_front();
      else         e = q1.pop_front();
      if (act !== e) begin
        miscompares++;
        $display("FAIL dut%0d record: got pc=%h insn=%h rd=%0d wd=%h trap=%b seq=%0d required pc=%h insn=%h rd=%0d wd=%h trap=%b seq=%0d",
                 id, act.pc, act.insn, act.rd_addr, act.rd_wdata, act.trap, act.seq,
                 e.pc, e.insn, e.rd_addr, e.rd_wdata, e.trap, e.seq);
      end
    end
  endtask

  // Monitor: every accepted head record is checked against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (tr0.tr_valid && ready)
        mon(0, {tr0.tr_pc, tr0.tr_insn, tr0.tr_rd_addr, tr0.tr_rd_wdata, tr0.tr_trap, tr0.tr_seq});
      if (tr1.tr_valid && ready)
        mon(1, {tr1.tr_pc, tr1.tr_insn, tr1.tr_rd_addr, tr1.tr_rd_wdata, tr1.tr_trap, tr1.tr_seq});
    end
  end

  task automatic reset_all();
    rst = 1'b1; en = 1'b0; ack = 1'b0; wen = 1'b0; wd1 = 1'b0; wd4 = 4'h0;
    cnt_done = 1'b0; pc_en = 1'b0; trap = 1'b0; clr = 1'b0; ready = 1'b0;
    rdt = 32'h0; adr = 32'h0; rda = 5'd0;
    step();
    step();
    rst = 1'b0;
    q0.delete();
    q1.delete();
    m_pc  = RPC;
    m_seq = 16'h0000;
  endtask

  // One instruction: fetch, optional serial rd write, retire strobe, commit
  task automatic run_insn(input logic [31:0] insn, input logic [4:0] rd, input logic [31:0] data,
                          input bit wr, input bit trap_mid, input bit en_i, input logic [31:0] nxt,
                          input bit pop_at_commit, input bit rst_at_commit, input bit chk_lat);
    rec_t r;
    ack = 1'b1; rdt = insn; en = en_i;
    step();
    ack = 1'b0; rda = rd;
    if (wr) begin
      for (int k = 0; k < 32; k++) begin
        wen  = 1'b1;
        wd1  = data[k];
        wd4  = (k >= 24) ? data[4*(k-24) +: 4] : 4'h0;
        trap = trap_mid && (k == 3);
        step();
      end
    end else begin
      trap = trap_mid;
      step();
    end
    wen = 1'b0; wd1 = 1'b0; wd4 = 4'h0; trap = 1'b0;
    cnt_done = 1'b1; pc_en = 1'b1; adr = nxt;
    if (!rst_at_commit) begin
      r.pc       = m_pc;
      r.insn     = insn;
      r.rd_addr  = (wr && rd != 5'd0) ? rd : 5'd0;
      r.rd_wdata = (wr && rd != 5'd0) ? data : 32'h0;
      r.trap     = trap_mid;
      r.seq      = m_seq;
      if (en_i) exp_push(r, pop_at_commit);
      m_pc  = nxt;
      m_seq = m_seq + 16'd1;
    end
    step();
    cnt_done = 1'b0; pc_en = 1'b0;
    if (pop_at_commit) ready = 1'b1;
    if (rst_at_commit) rst = 1'b1;
    if (chk_lat) chk("valid_one_edge_after_retire", {31'b0, tr0.tr_valid}, 32'h0);
    step();
    if (pop_at_commit) ready = 1'b0;
    if (rst_at_commit) rst = 1'b0;
    if (chk_lat) begin
      chk("valid_two_edges_w1", {31'b0, tr0.tr_valid}, 32'h1);
      chk("valid_two_edges_w4", {31'b0, tr1.tr_valid}, 32'h1);
    end
  endtask

  task automatic drain();
    ready = 1'b1;
    for (int i = 0; i < 60 && (q0.size() != 0 || q1.size() != 0 || tr0.tr_valid || tr1.tr_valid); i++)
      step();
    vectors++;
    if (q0.size() != 0 || q1.size() != 0 || tr0.tr_valid || tr1.tr_valid) begin
      miscompares++;
      $display("FAIL drain_timeout: left q0=%0d q1=%0d valid=%b%b required all empty",
               q0.size(), q1.size(), tr0.tr_valid, tr1.tr_valid);
    end
    ready = 1'b0;
  endtask

  initial begin
    // Reset state and a single ADDI x5 = 42
    reset_all();
    chk("reset_valid0", {31'b0, tr0.tr_valid}, 32'h0);
    chk("reset_valid1", {31'b0, tr1.tr_valid}, 32'h0);
    chk("reset_count0", {28'b0, cnt0}, 32'h0);
    chk("reset_count1", {28'b0, cnt1}, 32'h0);
    chk("reset_ovf0", {31'b0, ovf0}, 32'h0);
    run_insn(32'h02A0_0293, 5'd5, 32'h0000_002A, 1'b1, 1'b0, 1'b1, RPC + 32'd4, 1'b0, 1'b0, 1'b1);
    chk("addi_pc0", tr0.tr_pc, 32'h0000_1000);
    chk("addi_wd0", tr0.tr_rd_wdata, 32'h0000_002A);
    chk("addi_wd1", tr1.tr_rd_wdata, 32'h0000_002A);
    chk("addi_rd1", {27'b0, tr1.tr_rd_addr}, 32'd5);
    chk("addi_seq0", {16'b0, tr0.tr_seq}, 32'h0);
    drain();

    // Store (no rd write) then write to x0
    reset_all();
    run_insn(32'h0050_2223, 5'd4, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0000_2000, 1'b0, 1'b0, 1'b0);
    run_insn(32'h0070_0013, 5'd0, 32'h0000_0007, 1'b1, 1'b0, 1'b1, 32'h0000_2004, 1'b0, 1'b0, 1'b0);
    chk("store_count", {28'b0, cnt0}, 32'd2);
    chk("store_rd0", {27'b0, tr0.tr_rd_addr}, 32'd0);
    drain();

    // Ten retirements into an undrained FIFO
    reset_all();
    for (int i = 0; i < 10; i++)
      run_insn(32'h0000_0013, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, RPC + 32'(4 * (i + 1)), 1'b0, 1'b0, 1'b0);
    chk("full_count0", {28'b0, cnt0}, 32'd8);
    chk("full_count1", {28'b0, cnt1}, 32'd8);
    chk("full_ovf0", {31'b0, ovf0}, 32'h1);
    chk("full_ovf1", {31'b0, ovf1}, 32'h1);
    chk("drop_head_seq", {16'b0, tr0.tr_seq}, 32'd0);
    chk("evict_head_seq", {16'b0, tr1.tr_seq}, 32'd2);
    drain();
    chk("ovf_sticky", {31'b0, ovf1}, 32'h1);
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("ovf_clr0", {31'b0, ovf0}, 32'h0);
    chk("ovf_clr1", {31'b0, ovf1}, 32'h0);

    // Full FIFO with push and pop in the same cycle
    reset_all();
    for (int i = 0; i < 8; i++)
      run_insn(32'h0000_0013, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, RPC + 32'(4 * (i + 1)), 1'b0, 1'b0, 1'b0);
    chk("fill_count", {28'b0, cnt0}, 32'd8);
    run_insn(32'h0000_0013, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, RPC + 32'd36, 1'b1, 1'b0, 1'b0);
    chk("pushpop_count0", {28'b0, cnt0}, 32'd8);
    chk("pushpop_count1", {28'b0, cnt1}, 32'd8);
    chk("pushpop_ovf0", {31'b0, ovf0}, 32'h0);
    chk("pushpop_ovf1", {31'b0, ovf1}, 32'h0);
    chk("pushpop_head", {16'b0, tr0.tr_seq}, 32'd1);
    drain();

    // Trap flag, disabled trace gap, reset with a pending commit
    reset_all();
    run_insn(32'h0010_0093, 5'd1, 32'h0000_0001, 1'b1, 1'b1, 1'b1, RPC + 32'd4, 1'b0, 1'b0, 1'b0);
    run_insn(32'h0000_0013, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0, RPC + 32'd8, 1'b0, 1'b0, 1'b0);
    run_insn(32'h0020_0113, 5'd2, 32'h0000_0002, 1'b1, 1'b0, 1'b1, RPC + 32'd12, 1'b0, 1'b0, 1'b0);
    chk("gap_count", {28'b0, cnt0}, 32'd2);
    chk("trap_head", {31'b0, tr0.tr_trap}, 32'h1);
    drain();
    run_insn(32'h0000_0013, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1, RPC + 32'd16, 1'b0, 1'b1, 1'b0);
    chk("rst_pending_count0", {28'b0, cnt0}, 32'd0);
    chk("rst_pending_count1", {28'b0, cnt1}, 32'd0);
    step();
    step();
    chk("rst_pending_valid", {31'b0, tr0.tr_valid}, 32'h0);
    m_pc  = RPC;
    m_seq = 16'h0000;
    run_insn(32'h0030_0193, 5'd3, 32'h0000_0003, 1'b1, 1'b0, 1'b1, RPC + 32'd4, 1'b0, 1'b0, 1'b0);
    chk("post_rst_seq", {16'b0, tr1.tr_seq}, 32'd0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
